// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
//   Shared definitions for the bus traffic generator: FSM state encoding,
//   MODE encodings and a counter-width helper.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_REQ  = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    localparam int unsigned MODE_ALT   = 0;  // wr_ni follows address[0]
    localparam int unsigned MODE_WRITE = 1;  // writes only
    localparam int unsigned MODE_READ  = 2;  // reads only
    localparam int unsigned MODE_CHECK = 3;  // write, then read back and compare

    // Bits needed to hold values 0..max_val (at least 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at its all-ones value.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_client.sv
// traffic_client
//   Bus master traffic generator. Issues bursts of read/write requests over
//   an address window, separated by a programmable idle gap, with an ack
//   timeout and an optional write-then-readback check mode.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   enable    : 1 = generate traffic, 0 = stop after the current transaction
//   address   : transaction address
//   rq        : request, high in REQ only
//   ack       : acknowledge, honoured only while rq = 1
//   wr_ni     : 1 = read, 0 = write
//   dataW     : write data
//   dataR     : read data, sampled when ack = 1
//   busy      : high whenever not IDLE
//   timeout   : one-cycle pulse after an ack timeout
//   txn_count : completed transactions (saturating)
//   err_count : readback mismatches in check mode (saturating)
module traffic_client
    import bus_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH           = 8,
    parameter int unsigned ADDR_WIDTH           = 4,
    parameter int unsigned ADDR_SPACE_BEGINNING = 0,
    parameter int unsigned ADDR_SPACE_END       = 3,
    parameter int unsigned REQUEST_DELAY        = 10,
    parameter int unsigned BURST_LEN            = 1,
    parameter int unsigned MODE                 = 0,
    parameter int unsigned ACK_TIMEOUT          = 16,
    parameter int unsigned DATA_SEED            = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  rq,
    input  logic                  ack,
    output logic                  wr_ni,
    output logic [DATA_WIDTH-1:0] dataW,
    input  logic [DATA_WIDTH-1:0] dataR,
    output logic                  busy,
    output logic                  timeout,
    output logic [15:0]           txn_count,
    output logic [7:0]            err_count
);

    localparam int unsigned GW = cnt_width(REQUEST_DELAY);
    localparam int unsigned TW = cnt_width(ACK_TIMEOUT);
    localparam int unsigned BW = cnt_width(BURST_LEN);

    localparam logic [GW-1:0]         GAP_LAST   = GW'(REQUEST_DELAY - 1);
    localparam logic [TW-1:0]         WAIT_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [BW-1:0]         BURST_MAX  = BW'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(ADDR_SPACE_END);
    localparam logic [DATA_WIDTH-1:0] DATA_INIT  = DATA_WIDTH'(DATA_SEED);

    state_e state_q, state_d;

    logic [GW-1:0]         gap_q,   gap_d;
    logic [TW-1:0]         wait_q,  wait_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  timeout_q, timeout_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;  // last written value, for readback
    logic                  phase_q, phase_d;  // check mode: 0 = write, 1 = read

    logic done;     // transaction completes this cycle
    logic expire;   // ack limit reached without ack
    logic err_inc;

    // An ack on the last allowed cycle still completes the transaction.
    assign done   = (state_q == ST_REQ) && ack;
    assign expire = (state_q == ST_REQ) && !ack && (wait_q == WAIT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (!enable)                state_d = ST_IDLE;
                else if (gap_q == GAP_LAST) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (done || expire) state_d = ST_TURN;
            end
            ST_TURN: begin
                // timeout_q is high only in the TURN that follows a timeout,
                // so it doubles as the burst-abort flag.
                if (!timeout_q && (burst_q < BURST_MAX) && enable) state_d = ST_REQ;
                else if (enable)                                   state_d = ST_GAP;
                else                                               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        rq      = (state_q == ST_REQ);
        busy    = (state_q != ST_IDLE);
        timeout = timeout_q;
        address = addr_q;
        dataW   = data_q;
        wr_ni   = 1'b0;
        if (MODE == MODE_ALT)        wr_ni = addr_q[0];
        else if (MODE == MODE_READ)  wr_ni = 1'b1;
        else if (MODE == MODE_CHECK) wr_ni = phase_q;
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        gap_d     = '0;
        wait_d    = '0;
        burst_d   = burst_q;
        timeout_d = expire;
        addr_d    = addr_q;
        data_d    = data_q;
        wdata_d   = wdata_q;
        phase_d   = phase_q;

        if ((state_q == ST_GAP) && (state_d == ST_GAP)) gap_d  = gap_q + GW'(1);
        if ((state_q == ST_REQ) && (state_d == ST_REQ)) wait_d = wait_q + TW'(1);

        if (done) begin
            burst_d = burst_q + BW'(1);
        end else if ((state_q != ST_REQ) && (state_d != ST_REQ)) begin
            burst_d = '0;
        end

        if (done) begin
            if (!wr_ni) begin
                wdata_d = data_q;
                data_d  = data_q + DATA_WIDTH'(1);
            end
            if (MODE == MODE_CHECK) phase_d = ~phase_q;
            // In check mode the address moves on only after the readback.
            if ((MODE != MODE_CHECK) || phase_q) begin
                addr_d = (addr_q == ADDR_LAST) ? ADDR_FIRST : addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign err_inc = done && (MODE == MODE_CHECK) && phase_q && (dataR != wdata_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_q     <= '0;
            wait_q    <= '0;
            burst_q   <= '0;
            timeout_q <= 1'b0;
            addr_q    <= ADDR_FIRST;
            data_q    <= DATA_INIT;
            wdata_q   <= DATA_INIT;
            phase_q   <= 1'b0;
        end else begin
            gap_q     <= gap_d;
            wait_q    <= wait_d;
            burst_q   <= burst_d;
            timeout_q <= timeout_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wdata_q   <= wdata_d;
            phase_q   <= phase_d;
        end
    end

    sat_counter #(.WIDTH(16)) u_txn_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .inc_i   (done),
        .count_o (txn_count)
    );

    sat_counter #(.WIDTH(8)) u_err_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .inc_i   (err_inc),
        .count_o (err_count)
    );

endmodule

// File: tb/tb_traffic_client.sv
// tb_traffic_client
//   Four instances share clk/reset: [0] alternate mode defaults,
//   [1] check mode, [2] short ack timeout, [3] burst of three.
module tb_traffic_client;

    logic clk;
    logic rst_n;

    logic [3:0]       en_v, ack_v, rq_v, wr_v, busy_v, to_v;
    logic [3:0][3:0]  addr_v;
    logic [3:0][7:0]  dw_v, dr_v, err_v;
    logic [3:0][15:0] txn_v;

    int checks = 0;
    int errors = 0;

    traffic_client #(.MODE(0)) u_alt (
        .clk(clk), .reset(rst_n), .enable(en_v[0]), .address(addr_v[0]), .rq(rq_v[0]),
        .ack(ack_v[0]), .wr_ni(wr_v[0]), .dataW(dw_v[0]), .dataR(dr_v[0]), .busy(busy_v[0]),
        .timeout(to_v[0]), .txn_count(txn_v[0]), .err_count(err_v[0])
    );

    traffic_client #(.MODE(3), .REQUEST_DELAY(2)) u_chk (
        .clk(clk), .reset(rst_n), .enable(en_v[1]), .address(addr_v[1]), .rq(rq_v[1]),
        .ack(ack_v[1]), .wr_ni(wr_v[1]), .dataW(dw_v[1]), .dataR(dr_v[1]), .busy(busy_v[1]),
        .timeout(to_v[1]), .txn_count(txn_v[1]), .err_count(err_v[1])
    );

    traffic_client #(.ACK_TIMEOUT(4), .REQUEST_DELAY(3)) u_to (
        .clk(clk), .reset(rst_n), .enable(en_v[2]), .address(addr_v[2]), .rq(rq_v[2]),
        .ack(ack_v[2]), .wr_ni(wr_v[2]), .dataW(dw_v[2]), .dataR(dr_v[2]), .busy(busy_v[2]),
        .timeout(to_v[2]), .txn_count(txn_v[2]), .err_count(err_v[2])
    );

    traffic_client #(.BURST_LEN(3)) u_burst (
        .clk(clk), .reset(rst_n), .enable(en_v[3]), .address(addr_v[3]), .rq(rq_v[3]),
        .ack(ack_v[3]), .wr_ni(wr_v[3]), .dataW(dw_v[3]), .dataR(dr_v[3]), .busy(busy_v[3]),
        .timeout(to_v[3]), .txn_count(txn_v[3]), .err_count(err_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_rq(input int k);
        int n;
        n = 0;
        while (!rq_v[k] && n < 300) begin
            step();
            n++;
        end
        check($sformatf("rq_rise[%0d]", k), 32'(rq_v[k]), 32'd1);
    endtask

    // Holds the request for d cycles, checks the request fields stayed put,
    // then acks for one cycle with rdata. Returns on the sample after the ack edge.
    task automatic do_txn(input int k, input int d, input logic [7:0] rdata,
                          input logic [3:0] ea, input logic ew, input logic [7:0] ed);
        repeat (d) step();
        check($sformatf("hold[%0d]", k), {18'd0, addr_v[k], wr_v[k], dw_v[k], rq_v[k]},
              {18'd0, ea, ew, ed, 1'b1});
        ack_v[k] = 1'b1;
        dr_v[k]  = rdata;
        step();
        ack_v[k] = 1'b0;
        dr_v[k]  = '0;
    endtask

    typedef struct {
        int          dly;
        logic [3:0]  addr;
        logic        wr;
        logic [7:0]  dw;
        logic [15:0] txn;
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit   tr[64];
        int   f, pos, n, pulses;
        int   runs_exp[6];
        logic [3:0] ea;
        logic       ew;
        logic [7:0] ed, rd;

        // ack delay, expected address / wr_ni / dataW at request, txn_count after
        tbl[0] = '{2,  4'd0, 1'b0, 8'd1, 16'd1};
        tbl[1] = '{2,  4'd1, 1'b1, 8'd2, 16'd2};
        tbl[2] = '{0,  4'd2, 1'b0, 8'd2, 16'd3};
        tbl[3] = '{5,  4'd3, 1'b1, 8'd3, 16'd4};
        tbl[4] = '{2,  4'd0, 1'b0, 8'd3, 16'd5};
        tbl[5] = '{15, 4'd1, 1'b1, 8'd4, 16'd6};   // ack on the 16th (last) cycle

        runs_exp = '{1, 1, 1, 1, 1, 11};

        rst_n = 1'b0;
        en_v  = '0;
        ack_v = '0;
        dr_v  = '0;
        #12;
        check("rst_rq",    32'(rq_v[0]),   32'd0);
        check("rst_busy",  32'(busy_v[0]), 32'd0);
        check("rst_to",    32'(to_v[0]),   32'd0);
        check("rst_addr",  32'(addr_v[0]), 32'd0);
        check("rst_dataW", 32'(dw_v[0]),   32'd1);
        check("rst_txn",   32'(txn_v[0]),  32'd0);
        check("rst_err",   32'(err_v[0]),  32'd0);
        check("rst_wr",    32'(wr_v[0]),   32'd0);
        check("rst_wr_rd", 32'(wr_v[2]),   32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // ---- alternate mode: vector table ----
        en_v[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_rq(0);
            check($sformatf("v%0d_addr", i), 32'(addr_v[0]), 32'(tbl[i].addr));
            check($sformatf("v%0d_wr", i),   32'(wr_v[0]),   32'(tbl[i].wr));
            check($sformatf("v%0d_dw", i),   32'(dw_v[0]),   32'(tbl[i].dw));
            do_txn(0, tbl[i].dly, 8'd0, tbl[i].addr, tbl[i].wr, tbl[i].dw);
            check($sformatf("v%0d_txn", i),  32'(txn_v[0]),  32'(tbl[i].txn));
            check($sformatf("v%0d_to", i),   32'(to_v[0]),   32'd0);
            check($sformatf("v%0d_turn", i), 32'(rq_v[0]),   32'd0);
        end

        // ack while rq is low must be ignored
        ack_v[0] = 1'b1;
        repeat (5) step();
        check("stray_ack_rq", 32'(rq_v[0]), 32'd0);
        ack_v[0] = 1'b0;
        check("stray_ack_txn",  32'(txn_v[0]), 32'd6);
        check("stray_ack_addr", 32'(addr_v[0]), 32'd2);

        // enable dropped mid-request: finish it, then IDLE
        wait_rq(0);
        en_v[0] = 1'b0;
        do_txn(0, 2, 8'd0, 4'd2, 1'b0, 8'd4);
        check("endrop_txn",  32'(txn_v[0]),  32'd7);
        check("endrop_turn", 32'(busy_v[0]), 32'd1);
        step();
        check("endrop_idle", 32'(busy_v[0]), 32'd0);
        repeat (3) step();
        check("endrop_stay", {30'd0, busy_v[0], rq_v[0]}, 32'd0);
        check("endrop_addr", 32'(addr_v[0]), 32'd3);

        // reset asserted mid-request acts immediately
        en_v[0] = 1'b1;
        wait_rq(0);
        step();
        #3 rst_n = 1'b0;
        #1;
        check("midrst_rq",    32'(rq_v[0]),   32'd0);
        check("midrst_busy",  32'(busy_v[0]), 32'd0);
        check("midrst_addr",  32'(addr_v[0]), 32'd0);
        check("midrst_dataW", 32'(dw_v[0]),   32'd1);
        check("midrst_txn",   32'(txn_v[0]),  32'd0);
        check("midrst_wr",    32'(wr_v[0]),   32'd0);
        check("midrst_to",    32'(to_v[0]),   32'd0);
        en_v[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // ---- check mode: server corrupts readback at address 2 ----
        en_v[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ea = 4'(i / 2);
            ew = (i % 2) == 1;
            ed = 8'(i / 2 + 1);
            wait_rq(1);
            check($sformatf("chk%0d_addr", i), 32'(addr_v[1]), 32'(ea));
            check($sformatf("chk%0d_wr", i),   32'(wr_v[1]),   32'(ew));
            rd = (ea == 4'd2) ? (ed ^ 8'h55) : ed;
            do_txn(1, 1, rd, ea, ew, ew ? ed + 8'd1 : ed);
            if (i == 3) check("chk_err_pre", 32'(err_v[1]), 32'd0);
            if (i == 5) check("chk_err_a2",  32'(err_v[1]), 32'd1);
        end
        en_v[1] = 1'b0;
        check("chk_txn", 32'(txn_v[1]), 32'd8);
        check("chk_err", 32'(err_v[1]), 32'd1);

        // ---- ack never comes, timeout of 4 ----
        en_v[2] = 1'b1;
        wait_rq(2);
        n = 0;
        while (rq_v[2] && n < 20) begin
            n++;
            step();
        end
        check("to_rq_cycles", 32'(n), 32'd4);
        check("to_pulse", 32'(to_v[2]), 32'd1);
        pulses = int'(to_v[2]);
        en_v[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            pulses += int'(to_v[2]);
        end
        check("to_once",  32'(pulses),     32'd1);
        check("to_addr",  32'(addr_v[2]),  32'd0);
        check("to_txn",   32'(txn_v[2]),   32'd0);
        check("to_dataW", 32'(dw_v[2]),    32'd1);
        check("to_idle",  32'(busy_v[2]),  32'd0);

        // ---- burst of three with ack held high ----
        ack_v[3] = 1'b1;
        en_v[3]  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tr[i] = rq_v[3];
            step();
        end
        en_v[3]  = 1'b0;
        ack_v[3] = 1'b0;
        f = -1;
        for (int i = 63; i >= 0; i--) if (tr[i]) f = i;
        check("burst_seen", (f >= 0) ? 32'd1 : 32'd0, 32'd1);
        if (f < 0) f = 0;
        // high/low run lengths: three 1-cycle pulses split by one TURN cycle,
        // then TURN plus REQUEST_DELAY gap cycles low before the next burst
        pos = f;
        for (int r = 0; r < 6; r++) begin
            bit lvl;
            int len;
            lvl = (r % 2) == 0;
            len = 0;
            while (pos < 64 && tr[pos] == lvl) begin
                len++;
                pos++;
            end
            check($sformatf("burst_run%0d", r), 32'(len), 32'(runs_exp[r]));
        end
        check("burst_txn", 32'(txn_v[3]) >= 32'd4 ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
